// File: rtl/cmd_pkg.sv
// Shared opcodes, response codes and FSM types
// for the command dispatch stage.
package cmd_pkg;

  localparam logic [3:0] OP_SET_HDG = 4'h2;
  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_CAL     = 4'h6;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NACK = 8'hEE;
  localparam logic [7:0] RESP_TMO  = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT_DONE,
    WAIT_TX
  } state_t;

  typedef enum logic [1:0] {
    K_HDG,
    K_MOVE,
    K_CAL,
    K_ILL
  } op_kind_t;

  // Map a raw opcode nibble onto the small set of
  // operations the dispatcher knows how to run.
  function automatic op_kind_t decode_op(
    input logic [3:0] op
  );
    op_kind_t k;
    k = K_ILL;
    unique case (1'b1)
      (op == OP_SET_HDG): k = K_HDG;
      (op == OP_MOVE):    k = K_MOVE;
      (op == OP_CAL):     k = K_CAL;
      default:            k = K_ILL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/timeout_cnt.sv
// Saturating wait counter; flags when the limit
// count has been reached.
module timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 32'd1_000_000,
  parameter int unsigned TO_W        = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LIM =
    TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_cnt;

  // Count while enabled; park at the limit so the
  // value can never wrap back to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/cmd_dispatch.sv
// Command execution stage: captures a UART command,
// runs it, and returns a single response byte.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32'd1_000_000,
  parameter int unsigned TO_W        = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        trmt,
  output logic [7:0]  resp,
  input  logic        tx_done,
  output logic [11:0] desired_hdg,
  output logic        hdg_vld,
  output logic        move_req,
  output logic [11:0] move_dist,
  input  logic        move_done,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic        busy
);

  state_t      r_state;
  logic [15:0] r_cmd_q;
  logic        r_pend_move;
  logic        r_clr;
  logic        r_trmt;
  logic [7:0]  r_resp;
  logic [11:0] r_hdg;
  logic        r_hdg_vld;
  logic        r_move_req;
  logic [11:0] r_move_dist;
  logic        r_strt_cal;
  logic        r_busy;

  logic        w_done;
  logic        w_expired;
  logic        w_cnt_clr;
  logic        w_cnt_en;

  // Only the completion of the pending operation
  // counts; the other done input is ignored.
  assign w_done = r_pend_move ? move_done
                              : cal_done;

  assign w_cnt_clr = (r_state == DISPATCH);
  assign w_cnt_en  = (r_state == WAIT_DONE) &&
                     !w_done;

  timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_tmo (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expired(w_expired)
  );

  // Dispatch FSM with all handshake outputs
  // registered; pulses self-clear every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd_q     <= '0;
      r_pend_move <= 1'b0;
      r_clr       <= 1'b0;
      r_trmt      <= 1'b0;
      r_resp      <= 8'h00;
      r_hdg       <= '0;
      r_hdg_vld   <= 1'b0;
      r_move_req  <= 1'b0;
      r_move_dist <= '0;
      r_strt_cal  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_clr      <= 1'b0;
      r_trmt     <= 1'b0;
      r_hdg_vld  <= 1'b0;
      r_move_req <= 1'b0;
      r_strt_cal <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cmd_rdy) begin
            r_cmd_q <= cmd;
            r_clr   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= DISPATCH;
          end
        end
        DISPATCH: begin
          unique case (decode_op(r_cmd_q[15:12]))
            K_HDG: begin
              r_hdg     <= r_cmd_q[11:0];
              r_hdg_vld <= 1'b1;
              r_resp    <= RESP_ACK;
              r_trmt    <= 1'b1;
              r_state   <= WAIT_TX;
            end
            K_MOVE: begin
              r_move_dist <= r_cmd_q[11:0];
              r_move_req  <= 1'b1;
              r_pend_move <= 1'b1;
              r_state     <= WAIT_DONE;
            end
            K_CAL: begin
              r_strt_cal  <= 1'b1;
              r_pend_move <= 1'b0;
              r_state     <= WAIT_DONE;
            end
            default: begin
              r_resp  <= RESP_NACK;
              r_trmt  <= 1'b1;
              r_state <= WAIT_TX;
            end
          endcase
        end
        WAIT_DONE: begin
          // Completion beats a coincident timeout.
          if (w_done) begin
            r_resp  <= RESP_ACK;
            r_trmt  <= 1'b1;
            r_state <= WAIT_TX;
          end else if (w_expired) begin
            r_resp  <= RESP_TMO;
            r_trmt  <= 1'b1;
            r_state <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign clr_cmd_rdy = r_clr;
  assign trmt        = r_trmt;
  assign resp        = r_resp;
  assign desired_hdg = r_hdg;
  assign hdg_vld     = r_hdg_vld;
  assign move_req    = r_move_req;
  assign move_dist   = r_move_dist;
  assign strt_cal    = r_strt_cal;
  assign busy        = r_busy;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with a small
// timeout so the timeout path is reachable.
module tb_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = '0;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done = 1'b0;
  logic [11:0] desired_hdg;
  logic        hdg_vld;
  logic        move_req;
  logic [11:0] move_dist;
  logic        move_done = 1'b0;
  logic        strt_cal;
  logic        cal_done = 1'b0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  cmd_dispatch #(
    .TIMEOUT_CYC(100),
    .TO_W       (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .trmt       (trmt),
    .resp       (resp),
    .tx_done    (tx_done),
    .desired_hdg(desired_hdg),
    .hdg_vld    (hdg_vld),
    .move_req   (move_req),
    .move_dist  (move_dist),
    .move_done  (move_done),
    .strt_cal   (strt_cal),
    .cal_done   (cal_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] c);
    cmd     = c;
    cmd_rdy = 1'b1;
    step();
    check("clr_pulse", clr_cmd_rdy, 1);
    check("busy_cap", busy, 1);
    cmd_rdy = 1'b0;
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("idle_busy", busy, 0);
  endtask

  int n;

  initial begin
    // reset with cmd_rdy held high
    cmd     = 16'h2123;
    cmd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_clr", clr_cmd_rdy, 0);
      check("rst_trmt", trmt, 0);
    end
    check("rst_busy", busy, 0);
    check("rst_resp", resp, 8'h00);
    check("rst_hdg", desired_hdg, 0);
    check("rst_dist", move_dist, 0);
    check("rst_pulses",
          {hdg_vld, move_req, strt_cal}, 0);

    // SET_HDG picked up right after reset
    rst = 1'b0;
    step();
    check("hdg_clr", clr_cmd_rdy, 1);
    cmd_rdy = 1'b0;
    step();
    check("hdg_clr_1cyc", clr_cmd_rdy, 0);
    check("hdg_trmt", trmt, 1);
    check("hdg_vld", hdg_vld, 1);
    check("hdg_val", desired_hdg, 12'h123);
    check("hdg_resp", resp, 8'hA5);
    step();
    check("hdg_trmt_1cyc", trmt, 0);
    check("hdg_vld_1cyc", hdg_vld, 0);

    // second command while waiting for tx_done
    cmd     = 16'hF00D;
    cmd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wtx_noclr", clr_cmd_rdy, 0);
      check("wtx_resp", resp, 8'hA5);
    end
    finish_tx();
    check("wtx_idle_clr", clr_cmd_rdy, 0);
    step();
    check("ill_clr", clr_cmd_rdy, 1);
    cmd_rdy = 1'b0;
    step();
    check("ill_trmt", trmt, 1);
    check("ill_resp", resp, 8'hEE);
    check("ill_side",
          {hdg_vld, move_req, strt_cal}, 0);
    check("ill_hdg_keep", desired_hdg, 12'h123);
    step();
    finish_tx();

    // MOVE, done after 10 cycles, stray cal_done
    send_cmd(16'h4050);
    step();
    check("mv_req", move_req, 1);
    check("mv_dist", move_dist, 12'h050);
    check("mv_notrmt", trmt, 0);
    for (int i = 1; i < 10; i++) begin
      cal_done = (i == 3);
      step();
      check("mv_wait_trmt", trmt, 0);
      check("mv_req_1cyc", move_req, 0);
    end
    cal_done  = 1'b0;
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    check("mv_trmt", trmt, 1);
    check("mv_resp", resp, 8'hA5);
    step();
    check("mv_trmt_1cyc", trmt, 0);
    finish_tx();
    check("mv_dist_hold", move_dist, 12'h050);

    // CAL timeout, stray move_done ignored
    send_cmd(16'h6000);
    step();
    check("cal_strt", strt_cal, 1);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      move_done = (i == 20);
      step();
      if (trmt) begin
        n = i;
        break;
      end
    end
    move_done = 1'b0;
    check("tmo_latency", n, 100);
    check("tmo_resp", resp, 8'hE0);
    step();
    finish_tx();

    // done on the timeout edge: done wins
    send_cmd(16'h6ABC);
    step();
    for (int i = 1; i < 100; i++) begin
      step();
      check("race_wait", trmt, 0);
    end
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    check("race_trmt", trmt, 1);
    check("race_resp", resp, 8'hA5);
    step();
    finish_tx();

    // reset in the middle of WAIT_DONE
    send_cmd(16'h4ABC);
    step();
    check("abort_dist", move_dist, 12'hABC);
    for (int i = 0; i < 5; i++) step();
    rst       = 1'b1;
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_trmt", trmt, 0);
    check("abort_dist_rst", move_dist, 0);
    check("abort_resp", resp, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_trmt", trmt, 0);
      check("post_busy", busy, 0);
      check("post_clr", clr_cmd_rdy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
